// File: rtl/seq_gf_int_multiplier.sv
// seq_gf_int_multiplier: iterative unsigned / GF(2^WIDTH) multiplier retiring one multiplier bit per clock.
// Fixed WIDTH-cycle latency regardless of operand values, so timing leaks nothing about the data.
module seq_gf_int_multiplier #(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH:0]  POLY  = 9'h11B
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   z,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, p_q, p_d, p_sh;
    logic                 mode_q, mode_d, last;
    logic [2*WIDTH-1:0]   acc_q, acc_d, z_q, z_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            p_q     <= '0;
            acc_q   <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
        end
    end

    // Both datapaths step every CALC cycle; mode only selects which one lands in z.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        p_d     = p_q;
        acc_d   = acc_q;
        z_d     = z_q;
        last    = cnt_q == CW'(WIDTH-1);
        p_sh    = {p_q[WIDTH-2:0], 1'b0} ^ (p_q[WIDTH-1] ? POLY[WIDTH-1:0] : '0);
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b;
                mode_d  = mode;
                acc_d   = '0;
                p_d     = '0;
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                acc_d = b_q[cnt_q] ? acc_q + ({{WIDTH{1'b0}}, a_q} << cnt_q) : acc_q;
                p_d   = b_q[CW'(WIDTH-1) - cnt_q] ? p_sh ^ a_q : p_sh;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    z_d     = mode_q ? {{WIDTH{1'b0}}, p_d} : acc_d;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign out_valid = state_q == DONE;
    assign z         = z_q;
endmodule

// File: tb/tb_seq_gf_int_multiplier.sv
// tb_seq_gf_int_multiplier: directed checks of a WIDTH=8 AES-field instance and a WIDTH=4 instance.
module tb_seq_gf_int_multiplier;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid8 = 1'b0, in_ready8, mode8 = 1'b0, out_valid8, out_ready8 = 1'b1, busy8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] z8;
    logic        in_valid4 = 1'b0, in_ready4, mode4 = 1'b0, out_valid4, out_ready4 = 1'b1, busy4;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  z4;
    int          n_assert = 0, n_fail = 0;

    always #5 clk = ~clk;

    seq_gf_int_multiplier dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .mode(mode8), .out_valid(out_valid8), .out_ready(out_ready8), .z(z8), .busy(busy8)
    );

    seq_gf_int_multiplier #(.WIDTH(4), .POLY(5'h13)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
        .mode(mode4), .out_valid(out_valid4), .out_ready(out_ready4), .z(z4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called right after an edge with dut8 idle; returns sampling the first out_valid cycle.
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic m,
                        input logic [15:0] ez, input string tag);
        int n;
        a8 = ia; b8 = ib; mode8 = m; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0; a8 = ~ia; b8 = ~ib; mode8 = ~m;
        chk({tag, "_busy"}, busy8, 1);
        chk({tag, "_in_ready"}, in_ready8, 0);
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_z"}, z8, ez);
    endtask

    task automatic run4(input logic [3:0] ia, input logic [3:0] ib, input logic m,
                        input logic [7:0] ez, input string tag);
        int n;
        a4 = ia; b4 = ib; mode4 = m; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0; a4 = ~ia; b4 = ~ib; mode4 = ~m;
        n = 0;
        while (!out_valid4 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_z"}, z4, ez);
        @(posedge clk); #1;
        chk({tag, "_ready_back"}, in_ready4, 1);
    endtask

    task automatic fin8(input string tag);
        @(posedge clk); #1;
        chk({tag, "_out_valid_drop"}, out_valid8, 0);
        chk({tag, "_ready_back"}, in_ready8, 1);
        chk({tag, "_busy_drop"}, busy8, 0);
    endtask

    initial begin
        logic [7:0] prod;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready8", in_ready8, 1);
        chk("rst_out_valid8", out_valid8, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_z8", z8, 0);
        chk("rst_in_ready4", in_ready4, 1);
        chk("rst_z4", z4, 0);
        rst = 1'b0;

        run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "int_ff_ff");
        fin8("int_ff_ff");
        run8(8'h57, 8'h83, 1'b1, 16'h00C1, "gf_57_83");
        fin8("gf_57_83");
        run8(8'h57, 8'h13, 1'b1, 16'h00FE, "gf_57_13");
        fin8("gf_57_13");
        run8(8'h00, 8'hFF, 1'b0, 16'h0000, "int_zero");
        fin8("int_zero");

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) begin
                prod = 8'(i * j);
                run4(4'(i), 4'(j), 1'b0, prod, "int4_sweep");
            end
        run4(4'hF, 4'hF, 1'b0, 8'hE1, "int4_f_f");
        run4(4'hD, 4'hB, 1'b0, 8'h8F, "int4_d_b");
        run4(4'h2, 4'h8, 1'b1, 8'h03, "gf4_2_8");
        run4(4'h0, 4'hF, 1'b1, 8'h00, "gf4_0_f");

        out_ready8 = 1'b0;
        run8(8'h57, 8'h83, 1'b1, 16'h00C1, "bp");
        a8 = 8'h11; b8 = 8'h22; in_valid8 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_out_valid_hold", out_valid8, 1);
            chk("bp_z_hold", z8, 16'h00C1);
            chk("bp_in_ready_low", in_ready8, 0);
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        fin8("bp");
        chk("bp_z_kept", z8, 16'h00C1);
        @(posedge clk); #1;
        chk("bp_no_second_accept", in_ready8, 1);
        chk("bp_no_second_valid", out_valid8, 0);

        a8 = 8'hAA; b8 = 8'h55; mode8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_busy_before", busy8, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", in_ready8, 1);
        chk("abort_out_valid", out_valid8, 0);
        chk("abort_z", z8, 0);
        chk("abort_busy", busy8, 0);
        run8(8'h03, 8'h05, 1'b0, 16'h000F, "after_abort");
        fin8("after_abort");

        rst = 1'b1; in_valid8 = 1'b1; a8 = 8'h03; b8 = 8'h05;
        @(posedge clk); #1;
        rst = 1'b0; in_valid8 = 1'b0;
        chk("rst_wins_in_ready", in_ready8, 1);
        chk("rst_wins_busy", busy8, 0);
        repeat (9) @(posedge clk);
        #1;
        chk("rst_wins_no_result", out_valid8, 0);
        chk("rst_wins_z", z8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_gf_int_multiplier.md
Name: seq_gf_int_multiplier

Overview:
Parametrised, iterative multiplier. It retires one multiplier bit per clock.
It runs in one of two modes, selected per operation:
- Unsigned integer product: full 2*WIDTH result.
- GF(2^WIDTH) product: carry-less multiply reduced by a configurable polynomial. With the defaults this is the AES GF(2^8) field, used by MixColumns and InvMixColumns.
It replaces the fixed 4x4 combinational product table. A valid/ready handshake lets AES datapath stages share one instance.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..16.
- POLY, 9'h11B, irreducible reduction polynomial (WIDTH+1 bits). Only POLY[WIDTH-1:0] is used by the datapath.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operands and mode presented
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  multiplicand
- b  in  WIDTH  multiplier
- mode  in  1  0 = unsigned integer, 1 = GF(2^WIDTH)
- out_valid  out  1  result available on z
- out_ready  in  1  consumer takes the result
- z  out  2*WIDTH  product; in GF mode z[2*WIDTH-1:WIDTH] = 0
- busy  out  1  high in CALC or DONE

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, busy=0, z=0, state=IDLE, counter=0. Internal a, b and mode registers are cleared.
- States: IDLE -> CALC -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1, the block registers a, b and mode, clears the accumulator and counter, and moves to CALC.
  - The inputs need not be held after acceptance.
- CALC:
  - in_ready=0. The block performs exactly WIDTH iterations, one per edge. in_valid is ignored.
  - Integer mode, LSB-first: if b_reg[i]=1, acc = acc + (a_reg << i). The accumulator is 2*WIDTH bits and cannot overflow.
  - GF mode, MSB-first, using b_reg[WIDTH-1-i]:
    - Step 1: p = {p[WIDTH-2:0], 1'b0} XOR (p[WIDTH-1] ? POLY[WIDTH-1:0] : 0).
    - Step 2: if b_reg[WIDTH-1-i]=1, p = p XOR a_reg.
    - p is WIDTH bits.
  - On the edge that completes iteration WIDTH-1, the block moves to DONE.
  - On that same edge z is loaded: acc in integer mode, {WIDTH'b0, p} in GF mode. out_valid becomes 1.
- Latency:
  - The acceptance edge is edge k. out_valid is first high after edge k+WIDTH.
  - Example with WIDTH=8: the result is available 8 cycles after acceptance.
- DONE:
  - out_valid=1. z is held stable until the handshake.
  - On an edge with out_ready=1, out_valid goes to 0 and the state returns to IDLE. in_ready returns to 1 in the following cycle.
  - The block never overlaps operations: it accepts nothing in DONE.
  - Back-to-back throughput is one result per WIDTH+2 cycles when out_ready is held high.
- z between operations: z keeps its last result while out_valid=0. Consumers qualify z with out_valid.
- Zero operands: either operand equal to 0 still takes the full WIDTH cycles and gives z=0. There is no early exit, so timing is data-independent; this is a side-channel requirement for AES.
- Reset mid-operation: rst in CALC or DONE aborts the operation. All outputs return to their reset values on that edge, and the result is discarded.
- Simultaneous rst and in_valid: rst wins; nothing is accepted.
- mode sampling: mode is sampled only at acceptance. Changing mode during CALC has no effect.
- busy: busy equals NOT in_ready.

Test Plan:
- WIDTH=8, mode=0, a=8'hFF, b=8'hFF -> out_valid exactly 8 cycles after acceptance; z=16'hFE01 (65025).
- WIDTH=8, mode=1, a=8'h57, b=8'h83 -> z=16'h00C1 (FIPS-197 example). Then a=8'h57, b=8'h13 -> z=16'h00FE.
- WIDTH=4, mode=0: sweep all 256 (a,b) pairs -> z=a*b for every pair, e.g. 15*15 gives z=8'hE1, 13*11 gives z=8'h8F. This matches the legacy 4x4 table exactly.
- WIDTH=4, POLY=5'h13, mode=1, a=4'h2, b=4'h8 -> z=8'h03. Also a=4'h0, b=4'hF -> z=0 after 4 cycles, with no early completion.
- Backpressure: complete 8'h57*8'h83 in GF mode and hold out_ready=0 for 5 cycles:
  - out_valid stays 1, z stays 16'h00C1, in_ready stays 0, and a second in_valid is not accepted.
  - After out_ready=1, in_ready rises one cycle later.
- Reset mid-operation: assert rst on CALC iteration 3 -> the next cycle shows in_ready=1, out_valid=0, z=0. A new operation 8'h03*8'h05 in integer mode then gives z=16'h000F with normal latency.
